// File: rtl/memory_access.sv
// MEM stage: byte-addressable little-endian data memory with pipeline register and debug read port.
// Latency: one cycle for load data, pass-through fields and debug read; stores commit on the same edge.
// No backpressure: i_halt freezes the pipeline register and blocks stores; the debug port keeps running.
// Optional build macro MEM_ALIGN_CHECK_EN: traps misaligned half/word accesses and raises o_misaligned.
module memory_access #(
    parameter int NB_DATA   = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_halt,
    input  logic [NB_DATA-1:0]           i_ALU_result,
    input  logic [NB_DATA-1:0]           i_data_to_write_in_MEM,
    input  logic [4:0]                   i_write_reg,
    input  logic                         i_WB_write,
    input  logic                         i_WB_mem_to_reg,
    input  logic                         i_MEM_read,
    input  logic                         i_MEM_write,
    input  logic                         i_MEM_unsigned,
    input  logic [1:0]                   i_MEM_byte_half_word,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_debug_addr,
    output logic                         o_WB_write,
    output logic                         o_WB_mem_to_reg,
    output logic [4:0]                   o_write_reg,
    output logic [NB_DATA-1:0]           o_mem_data,
    output logic [NB_DATA-1:0]           o_ALU_result,
    output logic [NB_DATA-1:0]           o_debug_data,
    output logic                         o_misaligned
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [NB_DATA-1:0] mem [MEM_DEPTH];

    logic [AW-1:0]      word_idx;
    logic [1:0]         lane;
    logic               is_byte;
    logic               is_half;
    logic               is_word;
    logic               misaligned;
    logic               store_en;
    logic [NB_DATA-1:0] rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [NB_DATA-1:0] load_data;
    logic [3:0]         byte_en;
    logic [NB_DATA-1:0] wr_data;

    assign word_idx = i_ALU_result[AW+1:2];
    assign lane     = i_ALU_result[1:0];
    // Size code 10 is treated as a word access.
    assign is_byte  = (i_MEM_byte_half_word == 2'b00);
    assign is_half  = (i_MEM_byte_half_word == 2'b01);
    assign is_word  = ~is_byte & ~is_half;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (i_MEM_read | i_MEM_write) & ((is_half & lane[0]) | (is_word & (|lane)));
`else
    assign misaligned = 1'b0;
`endif

    // A store on the edge where reset is asserted is dropped.
    assign store_en = i_MEM_write & ~i_halt & i_reset_n & ~misaligned;
    assign rd_word  = mem[word_idx];

    always_comb begin
        rd_byte = rd_word[7:0];
        case (lane)
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            2'd3:    rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        load_data = rd_word;
        if (is_byte) begin
            load_data = i_MEM_unsigned ? {{(NB_DATA-8){1'b0}}, rd_byte}
                                       : {{(NB_DATA-8){rd_byte[7]}}, rd_byte};
        end else if (is_half) begin
            load_data = i_MEM_unsigned ? {{(NB_DATA-16){1'b0}}, rd_half}
                                       : {{(NB_DATA-16){rd_half[15]}}, rd_half};
        end
    end

    // Store data is replicated across lanes; byte enables pick the target lanes.
    always_comb begin
        byte_en = 4'b1111;
        wr_data = i_data_to_write_in_MEM;
        if (is_byte) begin
            byte_en = 4'b0001 << lane;
            wr_data = {4{i_data_to_write_in_MEM[7:0]}};
        end else if (is_half) begin
            byte_en = lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{i_data_to_write_in_MEM[15:0]}};
        end
    end

    // Memory array has no reset so its contents survive i_reset_n.
    always_ff @(posedge i_clk) begin
        if (store_en) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_WB_write      <= 1'b0;
            o_WB_mem_to_reg <= 1'b0;
            o_write_reg     <= '0;
            o_mem_data      <= '0;
            o_ALU_result    <= '0;
            o_debug_data    <= '0;
        end else begin
            o_debug_data <= mem[i_debug_addr];
            if (!i_halt) begin
                o_WB_write      <= i_WB_write & ~misaligned;
                o_WB_mem_to_reg <= i_WB_mem_to_reg;
                o_write_reg     <= i_write_reg;
                o_ALU_result    <= i_ALU_result;
                o_mem_data      <= (i_MEM_read & ~misaligned) ? load_data : '0;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            misaligned_q <= 1'b0;
        end else if (!i_halt && misaligned) begin
            misaligned_q <= 1'b1;
        end
    end

    assign o_misaligned = misaligned_q;
`else
    assign o_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: byte-array reference model, directed scenarios then random traffic.
module tb_memory_access;

    localparam int DEPTH = 256;
    localparam int BYTES = DEPTH * 4;

    logic        i_clk;
    logic        rst_n;
    logic        halt;
    logic [31:0] alu;
    logic [31:0] wdat;
    logic [4:0]  wreg;
    logic        wbw, m2r, rd, wr, uns;
    logic [1:0]  sz;
    logic [7:0]  dbg;

    logic        o_WB_write, o_WB_mem_to_reg, o_misaligned;
    logic [4:0]  o_write_reg;
    logic [31:0] o_mem_data, o_ALU_result, o_debug_data;

    logic        e_wb, e_m2r, e_mis;
    logic [4:0]  e_wr;
    logic [31:0] e_md, e_alu, e_dbg;

    logic [7:0]  mref [BYTES];
    int          n_checks = 0;
    int          n_err = 0;

    memory_access #(.NB_DATA(32), .MEM_DEPTH(DEPTH)) dut (
        .i_clk                  (i_clk),
        .i_reset_n              (rst_n),
        .i_halt                 (halt),
        .i_ALU_result           (alu),
        .i_data_to_write_in_MEM (wdat),
        .i_write_reg            (wreg),
        .i_WB_write             (wbw),
        .i_WB_mem_to_reg        (m2r),
        .i_MEM_read             (rd),
        .i_MEM_write            (wr),
        .i_MEM_unsigned         (uns),
        .i_MEM_byte_half_word   (sz),
        .i_debug_addr           (dbg),
        .o_WB_write             (o_WB_write),
        .o_WB_mem_to_reg        (o_WB_mem_to_reg),
        .o_write_reg            (o_write_reg),
        .o_mem_data             (o_mem_data),
        .o_ALU_result           (o_ALU_result),
        .o_debug_data           (o_debug_data),
        .o_misaligned           (o_misaligned)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("wb_write",   {31'd0, o_WB_write},      {31'd0, e_wb});
        chk("mem_to_reg", {31'd0, o_WB_mem_to_reg}, {31'd0, e_m2r});
        chk("write_reg",  {27'd0, o_write_reg},     {27'd0, e_wr});
        chk("mem_data",   o_mem_data,               e_md);
        chk("alu_result", o_ALU_result,             e_alu);
        chk("debug_data", o_debug_data,             e_dbg);
        chk("misaligned", {31'd0, o_misaligned},    {31'd0, e_mis});
    endtask

    function automatic logic [31:0] ref_word(input int unsigned byte_addr);
        logic [31:0] v;
        v = 0;
        for (int i = 0; i < 4; i++) v = v | (32'(mref[byte_addr + i]) << (8 * i));
        return v;
    endfunction

    // Advance one clock edge: predict outputs from the rules, then compare.
    task automatic tick();
        int unsigned a, nb, base;
        logic [31:0] val;
        logic        mis;
        a    = alu % BYTES;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = a - (a % nb);
        mis  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis  = (rd || wr) && (a % nb != 0);
`endif
        val = 0;
        for (int i = 0; i < int'(nb); i++) val = val | (32'(mref[base + i]) << (8 * i));
        if (!uns && nb < 4 && val[8*nb-1]) val = val - 32'(64'd1 << (8 * nb));
        if (!rst_n) begin
            {e_wb, e_m2r, e_mis} = 3'b000;
            e_wr = 0; e_md = 0; e_alu = 0; e_dbg = 0;
        end else begin
            e_dbg = ref_word(int'(dbg) * 4);
            if (!halt) begin
                e_wb  = wbw && !mis;
                e_m2r = m2r;
                e_wr  = wreg;
                e_alu = alu;
                e_md  = (rd && !mis) ? val : 32'd0;
                if (wr && !mis)
                    for (int i = 0; i < int'(nb); i++) mref[base + i] = 8'(wdat >> (8 * i));
                if (mis) e_mis = 1'b1;
            end
        end
        @(posedge i_clk);
        #1;
        check_all();
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w,
                          input logic [1:0] s, input logic u);
        halt = 0; alu = a; wdat = d; rd = r; wr = w; sz = s; uns = u;
        wreg = 5'(a); wbw = r; m2r = r;
    endtask

    initial begin
        rst_n = 1; halt = 0; alu = 0; wdat = 0; wreg = 0;
        wbw = 0; m2r = 0; rd = 0; wr = 0; uns = 0; sz = 0; dbg = 0;
        e_wb = 0; e_m2r = 0; e_mis = 0; e_wr = 0; e_md = 0; e_alu = 0; e_dbg = 0;
        #2 rst_n = 0;
        #1 check_all();
        tick();
        rst_n = 1;

        // Fill the whole memory so every later read has a known value.
        for (int i = 0; i < DEPTH; i++) begin
            set_op(32'(i * 4), $urandom, 0, 1, 2'b11, 0);
            dbg = 8'($urandom);
            tick();
        end

        set_op(32'h10, 32'hDEADBEEF, 0, 1, 2'b11, 0); tick();
        set_op(32'h10, 32'h0, 1, 0, 2'b11, 0);        tick();
        chk("load_word_deadbeef", o_mem_data, 32'hDEADBEEF);

        set_op(32'h20, 32'h000080FF, 0, 1, 2'b11, 0); tick();
        set_op(32'h20, 32'h0, 1, 0, 2'b00, 0);        tick();
        chk("load_byte_signed", o_mem_data, 32'hFFFFFFFF);
        set_op(32'h20, 32'h0, 1, 0, 2'b00, 1);        tick();
        chk("load_byte_unsigned", o_mem_data, 32'h000000FF);
        set_op(32'h20, 32'h0, 1, 0, 2'b01, 0);        tick();
        chk("load_half_signed", o_mem_data, 32'hFFFF80FF);
        set_op(32'h20, 32'h0, 1, 0, 2'b10, 0);        tick();
        chk("load_size10_word", o_mem_data, 32'h000080FF);

        set_op(32'h30, 32'h11223344, 0, 1, 2'b11, 0); tick();
        set_op(32'h31, 32'h000000AA, 0, 1, 2'b00, 0); tick();
        set_op(32'h0, 32'h0, 0, 0, 2'b11, 0); dbg = 8'd12; tick();
        set_op(32'h0, 32'h0, 0, 0, 2'b11, 0);         tick();
        chk("debug_byte_merge", o_debug_data, 32'h1122AA44);

        // Halted store must neither update memory nor move the pipeline register.
        set_op(32'h44, 32'h0, 1, 0, 2'b11, 0); dbg = 8'd16; tick();
        set_op(32'h40, 32'h5, 1, 1, 2'b11, 1); wreg = 5'd9; halt = 1; tick();
        halt = 0; rd = 0; wr = 0; tick();
        chk("halt_release_alu", o_ALU_result, 32'h40);
        tick();

`ifdef MEM_ALIGN_CHECK_EN
        set_op(32'h42, 32'h12345678, 0, 1, 2'b11, 0); wbw = 1; dbg = 8'd16; tick();
        chk("misaligned_set", {31'd0, o_misaligned}, 32'd1);
        set_op(32'h0, 32'h0, 0, 0, 2'b11, 0); tick(); tick();
        chk("misaligned_sticky", {31'd0, o_misaligned}, 32'd1);
`endif

        for (int n = 0; n < 300; n++) begin
            halt = ($urandom_range(7) == 0);
            alu  = $urandom;
            wdat = $urandom;
            wreg = 5'($urandom);
            {wbw, m2r, rd, wr, uns} = 5'($urandom);
            sz   = 2'($urandom);
            dbg  = 8'($urandom);
            tick();
        end

        // Mid-cycle reset clears outputs at once; memory is retained.
        set_op(32'h10, 32'h0, 1, 0, 2'b11, 0); dbg = 8'd4; tick();
        #3 rst_n = 0;
        #1;
        e_wb = 0; e_m2r = 0; e_mis = 0; e_wr = 0; e_md = 0; e_alu = 0; e_dbg = 0;
        check_all();
        set_op(32'h10, 32'h77777777, 0, 1, 2'b11, 0); tick();
        #3 rst_n = 1;
        set_op(32'h0, 32'h0, 0, 0, 2'b11, 0); dbg = 8'd4; tick();
        chk("mem_kept_after_reset", o_debug_data, ref_word(32'h10));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
